// File: rtl/legv8_pkg.sv
// Shared LEGv8 front-end definitions: opcode constants, instruction field
// bit positions and the fetch state encoding.
package legv8_pkg;

    localparam logic [9:0] OP_ADD  = 10'b1000101000;
    localparam logic [9:0] OP_SUB  = 10'b1100101100;
    localparam logic [9:0] OP_DIV  = 10'b0000011111;
    localparam logic [9:0] OP_MUL  = 10'b1111100000;
    localparam logic [9:0] OP_LI   = 10'b1010101010;
    localparam logic [9:0] OP_LDUR = 10'b1111011010;
    localparam logic [9:0] OP_STUR = 10'b1111011000;

    localparam int unsigned OPC_MSB   = 31;
    localparam int unsigned OPC_LSB   = 22;
    localparam int unsigned IMM12_MSB = 21;
    localparam int unsigned IMM12_LSB = 10;
    localparam int unsigned RM_MSB    = 20;
    localparam int unsigned RM_LSB    = 16;
    localparam int unsigned DT_MSB    = 20;
    localparam int unsigned DT_LSB    = 12;
    localparam int unsigned RN_MSB    = 9;
    localparam int unsigned RN_LSB    = 5;
    localparam int unsigned RD_MSB    = 4;
    localparam int unsigned RD_LSB    = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        ERR   = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory req/ack read channel between the fetch unit and imem.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit_field_split.sv
// Purely combinational IR-to-field slicer; also reused by the decode-stage
// debug tap.
module instr_field_split
    import legv8_pkg::*;
(
    input  logic [31:0] ir,
    output logic [9:0]  opcode,
    output logic [4:0]  rm,
    output logic [4:0]  rn,
    output logic [4:0]  rd,
    output logic [11:0] imm12,
    output logic [8:0]  dt_addr9
);
    always_comb begin
        opcode   = ir[OPC_MSB:OPC_LSB];
        rm       = ir[RM_MSB:RM_LSB];
        rn       = ir[RN_MSB:RN_LSB];
        rd       = ir[RD_MSB:RD_LSB];
        imm12    = ir[IMM12_MSB:IMM12_LSB];
        dt_addr9 = ir[DT_MSB:DT_LSB];
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// LEGv8 fetch stage: owns the PC, fetches over req/ack into the IR and exposes
// IR fields. Optional macro FETCH_TIMEOUT_EN adds an ack-wait timeout to ERR.
module instr_fetch_unit
    import legv8_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.master  imem,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_target,
    output logic                instr_valid,
    output logic [9:0]          opcode,
    output logic [4:0]          rm,
    output logic [4:0]          rn,
    output logic [4:0]          rd,
    output logic [11:0]         imm12,
    output logic [8:0]          dt_addr9,
    output logic [ADDR_W-1:0]   pc_out,
    output logic [15:0]         retired,
    output logic                fetch_err
);
    fetch_state_t      state, state_nx;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir;
    logic [9:0]        ir_opcode;
    logic              load_ir;
    logic              consume;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt;
    logic       timed_out;
    assign timed_out = (state == FETCH) && !imem.imem_ack && (wait_cnt == WAIT_LAST);
`endif

    assign load_ir = (state == FETCH) && imem.imem_ack;
    assign consume = (state == VALID) && !stall;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = FETCH;
            FETCH: begin
                if (imem.imem_ack) state_nx = VALID;
`ifdef FETCH_TIMEOUT_EN
                else if (timed_out) state_nx = ERR;
`endif
            end
            VALID: if (!stall) state_nx = FETCH;
`ifdef FETCH_TIMEOUT_EN
            ERR:   state_nx = ERR;
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            pc_out  <= '0;
            retired <= '0;
        end else begin
            if (load_ir) begin
                ir     <= imem.imem_rdata;
                pc_out <= pc;
            end
            if (consume) begin
                retired <= retired + 16'd1;
                pc      <= branch_taken ? {branch_target[ADDR_W-1:2], 2'b00} : pc + ADDR_W'(4);
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Counter is zero on every FETCH entry: cleared while outside FETCH.
    always_ff @(posedge clk) begin
        if (reset || state != FETCH) wait_cnt <= '0;
        else if (!imem.imem_ack)     wait_cnt <= wait_cnt + 8'd1;
    end
`endif

    instr_field_split u_split (
        .ir       (ir),
        .opcode   (ir_opcode),
        .rm       (rm),
        .rn       (rn),
        .rd       (rd),
        .imm12    (imm12),
        .dt_addr9 (dt_addr9)
    );

    assign imem.imem_req  = (state == FETCH);
    assign imem.imem_addr = pc;
    assign instr_valid    = (state == VALID);

`ifdef FETCH_TIMEOUT_EN
    assign fetch_err = (state == ERR);
    assign opcode    = (state == ERR) ? '0 : ir_opcode;
`else
    assign fetch_err = 1'b0;
    assign opcode    = ir_opcode;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed-vector bench for instr_fetch_unit (default build, no timeout).
module tb_instr_fetch_unit;
    import legv8_pkg::*;

    localparam int unsigned ADDR_W = 32;

    logic              clk;
    logic              reset;
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              instr_valid;
    logic [9:0]        opcode;
    logic [4:0]        rm, rn, rd;
    logic [11:0]       imm12;
    logic [8:0]        dt_addr9;
    logic [ADDR_W-1:0] pc_out;
    logic [15:0]       retired;
    logic              fetch_err;

    int unsigned vectors;
    int unsigned miscompares;

    localparam logic [31:0] W_ADD  = 32'h8A02_0023; // ADD rm=2 rn=1 rd=3
    localparam logic [31:0] W_SUB  = 32'hCB00_0005; // SUB rd=5
    localparam logic [31:0] W_MUL  = 32'hF800_0007; // MUL rd=7
    localparam logic [31:0] W_LDUR = 32'hF840_5043; // rn=2 rt=3 addr9=5

    instr_fetch_unit_if #(.ADDR_W(ADDR_W)) imem ();

    instr_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC ('0),
        .TIMEOUT  (64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem          (imem.master),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .opcode        (opcode),
        .rm            (rm),
        .rn            (rn),
        .rd            (rd),
        .imm12         (imm12),
        .dt_addr9      (dt_addr9),
        .pc_out        (pc_out),
        .retired       (retired),
        .fetch_err     (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step();
        step();
        vectors++;
        if (imem.imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: req=%b valid=%b err=%b, required 0/0/0", imem.imem_req, instr_valid, fetch_err);
        end
        vectors++;
        if (imem.imem_addr !== 32'h0 || pc_out !== 32'h0 || retired !== 16'h0 || opcode !== 10'h0) begin
            miscompares++;
            $display("FAIL reset_data: addr=%h pc_out=%h retired=%0d opcode=%b, required zeros", imem.imem_addr, pc_out, retired, opcode);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (imem.imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_req: req=%b, required 0", imem.imem_req);
        end
        step();
        vectors++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL first_req: req=%b addr=%h, required 1/00000000", imem.imem_req, imem.imem_addr);
        end
    endtask

    task automatic test_zero_latency;
        imem.imem_ack = 1'b1;
        imem.imem_rdata = W_ADD;
        step();
        imem.imem_ack = 1'b0;
        vectors++;
        if (instr_valid !== 1'b1 || opcode !== OP_ADD || pc_out !== 32'h0 || imem.imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL add_valid: valid=%b opcode=%b pc_out=%h req=%b, required 1/%b/0/0", instr_valid, opcode, pc_out, imem.imem_req, OP_ADD);
        end
        vectors++;
        if (rm !== 5'd2 || rn !== 5'd1 || rd !== 5'd3) begin
            miscompares++;
            $display("FAIL add_fields: rm=%0d rn=%0d rd=%0d, required 2/1/3", rm, rn, rd);
        end
        step();
        vectors++;
        if (instr_valid !== 1'b0 || imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h4 || retired !== 16'd1) begin
            miscompares++;
            $display("FAIL second_req: valid=%b req=%b addr=%h retired=%0d, required 0/1/4/1", instr_valid, imem.imem_req, imem.imem_addr, retired);
        end
        imem.imem_ack = 1'b1;
        imem.imem_rdata = W_SUB;
        step();
        imem.imem_ack = 1'b0;
        vectors++;
        if (instr_valid !== 1'b1 || opcode !== OP_SUB || pc_out !== 32'h4 || rd !== 5'd5) begin
            miscompares++;
            $display("FAIL sub_valid: valid=%b opcode=%b pc_out=%h rd=%0d, required 1/%b/4/5", instr_valid, opcode, pc_out, rd, OP_SUB);
        end
        step();
        vectors++;
        if (retired !== 16'd2 || imem.imem_addr !== 32'h8 || imem.imem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL after_two: retired=%0d addr=%h req=%b, required 2/8/1", retired, imem.imem_addr, imem.imem_req);
        end
    endtask

    task automatic test_delayed_ack;
        imem.imem_ack = 1'b0;
        imem.imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h8 || instr_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL wait_hold[%0d]: req=%b addr=%h valid=%b, required 1/8/0", i, imem.imem_req, imem.imem_addr, instr_valid);
            end
        end
        imem.imem_ack = 1'b1;
        imem.imem_rdata = W_MUL;
        step();
        imem.imem_ack = 1'b0;
        vectors++;
        if (instr_valid !== 1'b1 || opcode !== OP_MUL || rd !== 5'd7 || pc_out !== 32'h8) begin
            miscompares++;
            $display("FAIL mul_valid: valid=%b opcode=%b rd=%0d pc_out=%h, required 1/%b/7/8", instr_valid, opcode, rd, pc_out, OP_MUL);
        end
        step();
        vectors++;
        if (imem.imem_addr !== 32'hC || retired !== 16'd3) begin
            miscompares++;
            $display("FAIL after_mul: addr=%h retired=%0d, required c/3", imem.imem_addr, retired);
        end
    endtask

    task automatic test_stall;
        imem.imem_ack = 1'b1;
        imem.imem_rdata = W_LDUR;
        step();
        stall = 1'b1;
        imem.imem_rdata = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            branch_taken = (i == 2);
            branch_target = 32'h200;
            vectors++;
            if (instr_valid !== 1'b1 || imem.imem_req !== 1'b0 || opcode !== 10'b1111100001 ||
                rn !== 5'd2 || rd !== 5'd3 || dt_addr9 !== 9'd5 || imm12 !== 12'd20 || rm !== 5'd0 ||
                pc_out !== 32'hC || retired !== 16'd3 || imem.imem_addr !== 32'hC) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: valid=%b req=%b op=%b rn=%0d rd=%0d dt=%0d imm=%0d rm=%0d pc_out=%h ret=%0d addr=%h, required 1/0/1111100001/2/3/5/20/0/c/3/c",
                         i, instr_valid, imem.imem_req, opcode, rn, rd, dt_addr9, imm12, rm, pc_out, retired, imem.imem_addr);
            end
            step();
        end
        imem.imem_ack = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        step();
        vectors++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h10 || retired !== 16'd4) begin
            miscompares++;
            $display("FAIL stall_release: req=%b addr=%h retired=%0d, required 1/10/4", imem.imem_req, imem.imem_addr, retired);
        end
    endtask

    task automatic test_branch;
        imem.imem_ack = 1'b1;
        imem.imem_rdata = W_ADD;
        step();
        imem.imem_ack = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'h103;
        step();
        branch_taken = 1'b0;
        branch_target = 32'h0;
        vectors++;
        if (imem.imem_addr !== 32'h100 || imem.imem_req !== 1'b1 || retired !== 16'd5) begin
            miscompares++;
            $display("FAIL branch_redirect: addr=%h req=%b retired=%0d, required 100/1/5", imem.imem_addr, imem.imem_req, retired);
        end
        imem.imem_ack = 1'b1;
        imem.imem_rdata = W_SUB;
        step();
        imem.imem_ack = 1'b0;
        vectors++;
        if (pc_out !== 32'h100 || opcode !== OP_SUB) begin
            miscompares++;
            $display("FAIL branch_fetch: pc_out=%h opcode=%b, required 100/%b", pc_out, opcode, OP_SUB);
        end
        step();
        vectors++;
        if (imem.imem_addr !== 32'h104) begin
            miscompares++;
            $display("FAIL branch_seq: addr=%h, required 104", imem.imem_addr);
        end
    endtask

    task automatic test_reset_mid_fetch;
        imem.imem_ack = 1'b0;
        step();
        reset = 1'b1;
        imem.imem_ack = 1'b1;
        imem.imem_rdata = 32'hFFFF_FFFF;
        step();
        reset = 1'b0;
        vectors++;
        if (imem.imem_req !== 1'b0 || instr_valid !== 1'b0 || imem.imem_addr !== 32'h0 ||
            pc_out !== 32'h0 || opcode !== 10'h0 || retired !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_mid_fetch: req=%b valid=%b addr=%h pc_out=%h op=%b ret=%0d, required all zero",
                     imem.imem_req, instr_valid, imem.imem_addr, pc_out, opcode, retired);
        end
        step();
        imem.imem_ack = 1'b0;
        vectors++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0 || instr_valid !== 1'b0 || opcode !== 10'h0) begin
            miscompares++;
            $display("FAIL stale_ack_ignored: req=%b addr=%h valid=%b op=%b, required 1/0/0/0", imem.imem_req, imem.imem_addr, instr_valid, opcode);
        end
    endtask

    task automatic test_pc_wrap;
        imem.imem_ack = 1'b1;
        imem.imem_rdata = W_ADD;
        step();
        imem.imem_ack = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFE;
        step();
        branch_taken = 1'b0;
        vectors++;
        if (imem.imem_addr !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_branch: addr=%h, required fffffffc", imem.imem_addr);
        end
        imem.imem_ack = 1'b1;
        imem.imem_rdata = W_MUL;
        step();
        imem.imem_ack = 1'b0;
        step();
        vectors++;
        if (imem.imem_addr !== 32'h0 || retired !== 16'd2 || fetch_err !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_seq: addr=%h retired=%0d err=%b, required 0/2/0", imem.imem_addr, retired, fetch_err);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;
        imem.imem_ack = 1'b0;
        imem.imem_rdata = '0;
        test_reset();
        test_zero_latency();
        test_delayed_ack();
        test_stall();
        test_branch();
        test_reset_mid_fetch();
        test_pc_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
